// File: rtl/fios_operand_feeder.sv
// fios_operand_feeder: host-side operand server and result collector for the
// FIOS Montgomery multiplier. Holds a, b and p as s words of 17 bits, launches
// the multiplier with start_o, streams operand words on the multiplier's
// a_shift/b_fetch/p_fetch strobes and collects result words on res_push_i.
// Optional macro FIOS_FEEDER_CHAIN_EN: adds chain_i and turns the b memory and
// the result memory into two swappable banks so a result can feed the next run.
module fios_operand_feeder #(
  parameter int unsigned s     = 8,
  parameter int unsigned PE_NB = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  ld_en_i,
  input  logic [1:0]            ld_sel_i,
  input  logic [$clog2(s)-1:0]  ld_addr_i,
  input  logic [16:0]           ld_data_i,
  input  logic                  go_i,
`ifdef FIOS_FEEDER_CHAIN_EN
  input  logic                  chain_i,
`endif
  output logic                  busy_o,
  output logic                  start_o,
  output logic [PE_NB*17-1:0]   a_o,
  output logic [16:0]           b_o,
  output logic [16:0]           p_o,
  input  logic                  a_shift_i,
  input  logic                  b_fetch_i,
  input  logic                  p_fetch_i,
  input  logic                  res_push_i,
  input  logic [16:0]           res_i,
  input  logic                  done_i,
  output logic                  res_valid_o,
  output logic                  err_o,
  input  logic [$clog2(s)-1:0]  rd_addr_i,
  output logic [16:0]           rd_data_o
);

  localparam int unsigned DW = 17;
  localparam int unsigned AW = $clog2(s);
  localparam int unsigned CW = $clog2(s + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]          state_q;
  logic [1:0]          state_nxt;
  logic [AW-1:0]       b_idx_q;
  logic [AW-1:0]       b_idx_nxt;
  logic [AW-1:0]       p_idx_q;
  logic [AW-1:0]       p_idx_nxt;
  logic [CW-1:0]       a_base_q;
  logic [CW-1:0]       a_base_nxt;
  logic [CW-1:0]       r_idx_q;
  logic [CW-1:0]       r_idx_nxt;
  logic                go_acc;
  logic                err_nxt;
  logic                ld_ok;
  logic                a_we;
  logic                b_we;
  logic                p_we;
  logic                r_we;
  logic                ld_addr_ok;
  logic                rd_addr_ok;
  logic                bsel_q;
  logic                bsel_nxt;
  logic [DW-1:0]       b_rd;
  logic [DW-1:0]       rd_word;
  logic [PE_NB*DW-1:0] a_win;

  // Operand and result storage; bank0/bank1 hold b and results, bsel picks the b bank
  logic [DW-1:0] a_mem [s];
  logic [DW-1:0] p_mem [s];
  logic [DW-1:0] bank0 [s];
  logic [DW-1:0] bank1 [s];

  assign ld_addr_ok = (32'(ld_addr_i) < s);
  assign rd_addr_ok = (32'(rd_addr_i) < s);

`ifdef FIOS_FEEDER_CHAIN_EN
  // Bank select flips on a chained launch so the last result becomes b
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) bsel_q <= 1'b0;
    else          bsel_q <= bsel_nxt;
  end

  assign bsel_nxt = go_acc ? (bsel_q ^ chain_i) : bsel_q;
`else
  assign bsel_q   = 1'b0;
  assign bsel_nxt = 1'b0;
`endif

  // State register
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_nxt;
  end

  // Next-state, index update and write-enable decode
  always_comb begin
    state_nxt  = state_q;
    go_acc     = 1'b0;
    ld_ok      = 1'b0;
    r_we       = 1'b0;
    err_nxt    = err_o;
    b_idx_nxt  = b_idx_q;
    p_idx_nxt  = p_idx_q;
    a_base_nxt = a_base_q;
    r_idx_nxt  = r_idx_q;

    case (state_q)
      IDLE, DONE: begin
        ld_ok = ld_en_i;
        if (go_i) begin
          state_nxt  = RUN;
          go_acc     = 1'b1;
          b_idx_nxt  = '0;
          p_idx_nxt  = '0;
          a_base_nxt = '0;
          r_idx_nxt  = '0;
          err_nxt    = 1'b0;
        end
      end
      RUN: begin
        if (b_fetch_i)
          b_idx_nxt = (b_idx_q == AW'(s - 1)) ? '0 : b_idx_q + AW'(1);
        if (p_fetch_i)
          p_idx_nxt = (p_idx_q == AW'(s - 1)) ? '0 : p_idx_q + AW'(1);
        if (a_shift_i && (a_base_q < CW'(s))) begin
          if (32'(a_base_q) + PE_NB >= s) a_base_nxt = CW'(s);
          else                            a_base_nxt = CW'(32'(a_base_q) + PE_NB);
        end
        if (res_push_i) begin
          if (r_idx_q < CW'(s)) begin
            r_we      = 1'b1;
            r_idx_nxt = r_idx_q + CW'(1);
          end else begin
            err_nxt   = 1'b1;
          end
        end
        // Count is judged after any push landing in the same cycle
        if (done_i) begin
          state_nxt = DONE;
          if (r_idx_nxt != CW'(s)) err_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign a_we = ld_ok && ld_addr_ok && (ld_sel_i == 2'd0);
  assign b_we = ld_ok && ld_addr_ok && (ld_sel_i == 2'd1);
  assign p_we = ld_ok && ld_addr_ok && (ld_sel_i == 2'd2);

  // Next a window: words past the end of the operand read as zero
  always_comb begin
    a_win = '0;
    for (int unsigned j = 0; j < PE_NB; j++) begin
      if (32'(a_base_nxt) + j < s)
        a_win[DW*j +: DW] = a_mem[AW'(32'(a_base_nxt) + j)];
    end
  end

  // b is read from the bank that will be current after this edge
  assign b_rd    = bsel_nxt ? bank1[b_idx_nxt] : bank0[b_idx_nxt];
  assign rd_word = rd_addr_ok ? (bsel_q ? bank0[rd_addr_i] : bank1[rd_addr_i]) : '0;

  // Memory writes: host loads outside RUN, result pushes inside RUN
  always_ff @(posedge clock_i) begin
    if (a_we) a_mem[ld_addr_i] <= ld_data_i;
    if (p_we) p_mem[ld_addr_i] <= ld_data_i;
    if (b_we) begin
      if (bsel_q) bank1[ld_addr_i] <= ld_data_i;
      else        bank0[ld_addr_i] <= ld_data_i;
    end
    if (r_we) begin
      if (bsel_q) bank0[r_idx_q[AW-1:0]] <= res_i;
      else        bank1[r_idx_q[AW-1:0]] <= res_i;
    end
  end

  // Indices, status flags and registered operand/read outputs
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      b_idx_q     <= '0;
      p_idx_q     <= '0;
      a_base_q    <= '0;
      r_idx_q     <= '0;
      start_o     <= 1'b0;
      busy_o      <= 1'b0;
      res_valid_o <= 1'b0;
      err_o       <= 1'b0;
      a_o         <= '0;
      b_o         <= '0;
      p_o         <= '0;
      rd_data_o   <= '0;
    end else begin
      b_idx_q     <= b_idx_nxt;
      p_idx_q     <= p_idx_nxt;
      a_base_q    <= a_base_nxt;
      r_idx_q     <= r_idx_nxt;
      start_o     <= go_acc;
      busy_o      <= (state_nxt == RUN);
      res_valid_o <= (state_nxt == DONE);
      err_o       <= err_nxt;
      rd_data_o   <= rd_word;
      if (go_acc || (state_q == RUN)) begin
        a_o <= a_win;
        b_o <= b_rd;
        p_o <= p_mem[p_idx_nxt];
      end
    end
  end

endmodule

// File: tb/tb_fios_operand_feeder.sv
// Bench for fios_operand_feeder: directed scenarios plus random traffic, with
// a behavioural model checked against two instances (PE_NB = 8 and PE_NB = 3).
module tb_fios_operand_feeder;

  localparam int unsigned S  = 8;
  localparam int unsigned DW = 17;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;
`ifdef FIOS_FEEDER_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic ld_en, go, chain_in, a_shift, b_fetch, p_fetch, res_push, done;
  logic [1:0]  ld_sel;
  logic [2:0]  ld_addr, rd_addr;
  logic [16:0] ld_data, res;

  logic busy8, start8, rv8, err8, busy3, start3, rv3, err3;
  logic [8*DW-1:0] a8;
  logic [3*DW-1:0] a3;
  logic [16:0] b8, p8, rd8, b3, p3, rd3;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  fios_operand_feeder #(.s(S), .PE_NB(8)) dut8 (
    .clock_i(clk), .reset_i(rst_n), .ld_en_i(ld_en), .ld_sel_i(ld_sel),
    .ld_addr_i(ld_addr), .ld_data_i(ld_data), .go_i(go),
`ifdef FIOS_FEEDER_CHAIN_EN
    .chain_i(chain_in),
`endif
    .busy_o(busy8), .start_o(start8), .a_o(a8), .b_o(b8), .p_o(p8),
    .a_shift_i(a_shift), .b_fetch_i(b_fetch), .p_fetch_i(p_fetch),
    .res_push_i(res_push), .res_i(res), .done_i(done),
    .res_valid_o(rv8), .err_o(err8), .rd_addr_i(rd_addr), .rd_data_o(rd8)
  );

  fios_operand_feeder #(.s(S), .PE_NB(3)) dut3 (
    .clock_i(clk), .reset_i(rst_n), .ld_en_i(ld_en), .ld_sel_i(ld_sel),
    .ld_addr_i(ld_addr), .ld_data_i(ld_data), .go_i(go),
`ifdef FIOS_FEEDER_CHAIN_EN
    .chain_i(chain_in),
`endif
    .busy_o(busy3), .start_o(start3), .a_o(a3), .b_o(b3), .p_o(p3),
    .a_shift_i(a_shift), .b_fetch_i(b_fetch), .p_fetch_i(p_fetch),
    .res_push_i(res_push), .res_i(res), .done_i(done),
    .res_valid_o(rv3), .err_o(err3), .rd_addr_i(rd_addr), .rd_data_o(rd3)
  );

  // ---------------- behavioural model ----------------
  int m_state = M_IDLE;
  int bi = 0, pi = 0, nsh = 0, ri = 0;
  bit swapped = 1'b0;
  logic [16:0] av [S];
  logic [16:0] pv [S];
  logic [16:0] bv [S];
  logic [16:0] rv [S];
  bit bk [S];
  bit rk [S];

  logic e_start, e_busy, e_rv, e_err, e_bk, e_rd_k;
  logic [8*DW-1:0] e_a8;
  logic [3*DW-1:0] e_a3;
  logic [16:0] e_b, e_p, e_rd;

  // Exchange the b operand and result vectors (chained launch / reset undo)
  task automatic swap_banks();
    logic [16:0] t;
    bit tk;
    for (int k = 0; k < S; k++) begin
      t = bv[k]; bv[k] = rv[k]; rv[k] = t;
      tk = bk[k]; bk[k] = rk[k]; rk[k] = tk;
    end
  endtask

  // a window after n shifts of pe words each
  function automatic logic [8*DW-1:0] win(input int pe, input int n);
    logic [8*DW-1:0] w;
    w = '0;
    for (int j = 0; j < pe; j++)
      if (n * pe + j < S) w[DW*j +: DW] = av[n * pe + j];
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit was_run, go_ok, sw, pw;
    int pa;
    logic [16:0] pd;
    logic [8*DW-1:0] w;
    if (!rst_n) begin
      if (swapped) begin swap_banks(); swapped = 1'b0; end
      m_state = M_IDLE; bi = 0; pi = 0; nsh = 0; ri = 0;
      e_start = 0; e_busy = 0; e_rv = 0; e_err = 0;
      e_a8 = '0; e_a3 = '0; e_b = '0; e_bk = 1; e_p = '0; e_rd = '0; e_rd_k = 1;
    end else begin
      e_rd = rv[rd_addr]; e_rd_k = rk[rd_addr];
      was_run = (m_state == M_RUN);
      go_ok = 0; sw = 0; pw = 0; pa = 0; pd = '0;
      if (!was_run) begin
        if (go) begin
          go_ok = 1; m_state = M_RUN;
          bi = 0; pi = 0; nsh = 0; ri = 0; e_err = 0;
          if (CHAIN && chain_in) begin swap_banks(); swapped = !swapped; sw = 1; end
        end
      end else begin
        if (b_fetch) bi = (bi + 1) % S;
        if (p_fetch) pi = (pi + 1) % S;
        if (a_shift && nsh < S) nsh++;
        if (res_push) begin
          if (ri < S) begin pw = 1; pa = ri; pd = res; ri++; end
          else e_err = 1;
        end
        if (done) begin
          m_state = M_DONE;
          if (ri != S) e_err = 1;
        end
      end
      e_start = go_ok;
      if (go_ok || was_run) begin
        e_b = bv[bi]; e_bk = bk[bi]; e_p = pv[pi];
        w = win(8, nsh); e_a8 = w;
        w = win(3, nsh); e_a3 = w[3*DW-1:0];
      end
      if (!was_run && ld_en) begin
        case (ld_sel)
          2'd0: av[ld_addr] = ld_data;
          2'd1: if (sw) begin rv[ld_addr] = ld_data; rk[ld_addr] = 1; end
                else    begin bv[ld_addr] = ld_data; bk[ld_addr] = 1; end
          2'd2: pv[ld_addr] = ld_data;
          default: ;
        endcase
      end
      if (pw) begin rv[pa] = pd; rk[pa] = 1; end
      e_busy = (m_state == M_RUN);
      e_rv   = (m_state == M_DONE);
    end
  end

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ctl8", 136'({start8, busy8, rv8, err8}), 136'({e_start, e_busy, e_rv, e_err}));
      chk("m_ctl3", 136'({start3, busy3, rv3, err3}), 136'({e_start, e_busy, e_rv, e_err}));
      chk("m_a8", a8, e_a8);
      chk("m_a3", 136'(a3), 136'(e_a3));
      chk("m_p", 136'({p8, p3}), 136'({e_p, e_p}));
      if (e_bk)   chk("m_b",  136'({b8, b3}),   136'({e_b, e_b}));
      if (e_rd_k) chk("m_rd", 136'({rd8, rd3}), 136'({e_rd, e_rd}));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input logic [1:0] sel, input int addr, input logic [16:0] d);
    ld_en = 1; ld_sel = sel; ld_addr = 3'(addr); ld_data = d;
    tick();
    ld_en = 0;
  endtask

  task automatic pulse_go(input logic ch);
    go = 1; chain_in = ch;
    tick();
    go = 0; chain_in = 0;
  endtask

  task automatic push(input logic [16:0] d);
    res_push = 1; res = d;
    tick();
    res_push = 0;
  endtask

  task automatic pulse_done();
    done = 1;
    tick();
    done = 0;
  endtask

`ifdef FIOS_FEEDER_CHAIN_EN
  logic [16:0] rr [S];
`endif

  initial begin
    logic [8*DW-1:0] x8;
    ld_en = 0; go = 0; chain_in = 0; a_shift = 0; b_fetch = 0; p_fetch = 0;
    res_push = 0; done = 0; ld_sel = 0; ld_addr = 0; ld_data = 0; res = 0;
    rd_addr = 0; rst_n = 1;
    for (int k = 0; k < S; k++) begin bk[k] = 0; rk[k] = 0; end

    #3 rst_n = 0;
    #1;
    chk("rst_ctl", 136'({start8, busy8, rv8, err8}), 136'(0));
    chk("rst_data", 136'({b8, p8, rd8}), 136'(0));
    chk("rst_a", a8, '0);
    tick();
    rst_n = 1;
    chk_en = 1;

    for (int k = 0; k < S; k++) begin
      load(2'd0, k, 17'(k + 1));
      load(2'd1, k, 17'(k + 9));
      load(2'd2, k, 17'(k + 17));
    end

    // Basic run
    pulse_go(0);
    for (int j = 0; j < 8; j++) x8[DW*j +: DW] = 17'(j + 1);
    chk("go_start", 136'(start8), 136'(1));
    chk("go_a8", a8, x8);
    chk("go_a3", 136'(a3), 136'({17'd3, 17'd2, 17'd1}));
    chk("go_b", 136'(b8), 136'(17'd9));
    for (int k = 0; k < 8; k++) begin
      b_fetch = 1; p_fetch = (k < 2);
      tick();
      b_fetch = 0; p_fetch = 0;
      chk("b_stream", 136'(b8), 136'(17'((k + 1) % 8 + 9)));
    end
    chk("p_after2", 136'(p8), 136'(17'd19));

    // Fold window on the PE_NB = 3 instance
    for (int k = 0; k < 3; k++) begin
      a_shift = 1;
      tick();
      a_shift = 0;
      case (k)
        0:       chk("fold1", 136'(a3), 136'({17'd6, 17'd5, 17'd4}));
        1:       chk("fold2", 136'(a3), 136'({17'd0, 17'd8, 17'd7}));
        default: chk("fold3", 136'(a3), 136'(0));
      endcase
    end

    // Result path
    for (int k = 0; k < 8; k++) push(17'h100 + 17'(k));
    pulse_done();
    chk("res_valid", 136'({rv8, err8, busy8}), 136'(3'b100));
    rd_addr = 5;
    tick();
    chk("rd5", 136'(rd8), 136'(17'h105));

    // Overflowing push
    pulse_go(0);
    chk("go_clr_valid", 136'({rv8, busy8}), 136'(2'b01));
    for (int k = 0; k < 9; k++) begin
      push(17'($urandom));
      if (k == 7) chk("eight_ok", 136'(err8), 136'(0));
    end
    chk("ovf_err", 136'(err8), 136'(1));
    pulse_done();
    chk("ovf_err_done", 136'(err8), 136'(1));

    // go clears err, short run sets it
    pulse_go(0);
    chk("go_clr_err", 136'(err8), 136'(0));
    for (int k = 0; k < 6; k++) push(17'($urandom));
    pulse_done();
    chk("short_err", 136'(err8), 136'(1));

    // Reset mid-run
    pulse_go(0);
    for (int k = 0; k < 3; k++) begin
      b_fetch = 1;
      tick();
      b_fetch = 0;
    end
    chk("pre_rst_b", 136'(b8), 136'(17'd12));
    #2 rst_n = 0;
    #1;
    chk("arst_data", 136'({b8, p8, start8, busy8, err8}), 136'(0));
    chk("arst_a", a8, '0);
    tick();
    rst_n = 1;
    pulse_go(0);
    chk("rerun_b", 136'({start8, b8}), 136'({1'b1, 17'd9}));
    pulse_done();

`ifdef FIOS_FEEDER_CHAIN_EN
    pulse_go(0);
    for (int k = 0; k < S; k++) begin
      rr[k] = 17'($urandom);
      push(rr[k]);
    end
    pulse_done();
    pulse_go(1);
    chk("chain_b0", 136'(b8), 136'(rr[0]));
    load(2'd1, 0, 17'h1ffff);
    for (int k = 0; k < 8; k++) begin
      b_fetch = 1;
      tick();
      b_fetch = 0;
      chk("chain_b", 136'(b8), 136'(rr[(k + 1) % 8]));
    end
    pulse_done();
`endif

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      ld_en    = ($urandom_range(3) == 0);
      ld_sel   = 2'($urandom);
      ld_addr  = 3'($urandom);
      ld_data  = 17'($urandom);
      go       = ($urandom_range(19) == 0);
      chain_in = 1'($urandom);
      a_shift  = ($urandom_range(3) == 0);
      b_fetch  = 1'($urandom);
      p_fetch  = 1'($urandom);
      res_push = ($urandom_range(1) == 0);
      res      = 17'($urandom);
      done     = ($urandom_range(19) == 0);
      rd_addr  = 3'($urandom);
      tick();
    end
    ld_en = 0; go = 0; chain_in = 0; a_shift = 0; b_fetch = 0; p_fetch = 0;
    res_push = 0; done = 0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fios_operand_feeder.md
Name: fios_operand_feeder

Overview:
- Host-side operand server and result collector for the FIOS Montgomery multiplier top.
- Stores operands a, b and p as s words of 17 bits each, and issues start to the multiplier.
- Serves a, b and p words on the multiplier's a_shift, b_fetch and p_fetch strobes.
- Captures result words on RES_push and reports completion on done. The host loads operands and reads results through a simple word port.

Parameters:
- s, 8: number of 17-bit words per operand.
- PE_NB, 8: number of processing elements. Equals the width of the a window in words (1 ≤ PE_NB ≤ s).

Ports:
- clock_i  in  1  single clock; all state changes on its rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- ld_en_i  in  1  host load strobe.
- ld_sel_i  in  2  load target: 0 = a, 1 = b, 2 = p, 3 = ignored.
- ld_addr_i  in  $clog2(s)  word index for the load.
- ld_data_i  in  17  load word.
- go_i  in  1  host request to launch one multiplication.
- busy_o  out  1  high in the RUN state.
- start_o  out  1  one-cycle start pulse to the multiplier.
- a_o  out  PE_NB*17  current a window; word j sits at bits [17j+16:17j].
- b_o  out  17  current b word.
- p_o  out  17  current p word.
- a_shift_i  in  1  multiplier request to advance the a window.
- b_fetch_i  in  1  multiplier has consumed b_o.
- p_fetch_i  in  1  multiplier has consumed p_o.
- res_push_i  in  1  result word valid.
- res_i  in  17  result word.
- done_i  in  1  multiplier completion.
- res_valid_o  out  1  result buffer complete.
- err_o  out  1  sticky protocol error.
- rd_addr_i  in  $clog2(s)  host result read index.
- rd_data_o  out  17  registered read data, one cycle of latency.

Behaviour:
- Reset (reset_i low, asynchronous):
  - FSM goes to IDLE.
  - All indices clear to 0.
  - start_o, busy_o, res_valid_o and err_o are 0.
  - a_o, b_o, p_o and rd_data_o are 0.
  - Memory contents are not cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ld_en_i writes the selected memory.
  - go_i moves to RUN. In the same edge: start_o pulses for exactly one cycle, and the b, p, a and result indices clear to 0.
- RUN:
  - Loads are ignored.
  - go_i is ignored.
  - busy_o = 1.
- DONE:
  - res_valid_o = 1 until the next go_i.
  - Loads are allowed.
  - go_i behaves as in IDLE and clears res_valid_o.
- Serving b and p:
  - b_o = b_mem[b_idx] and p_o = p_mem[p_idx], both registered. b_idx and p_idx are 0 on the first cycle of RUN.
  - A b_fetch_i edge at cycle t advances b_idx, and the new word appears at t+1.
  - b_idx wraps from s-1 to 0, because b is re-streamed every outer iteration. p behaves the same on p_fetch_i.
  - Fetch strobes outside RUN are ignored.
- Serving a:
  - a_o word j = a_mem[a_base + j], or 0 when a_base + j ≥ s.
  - a_shift_i adds PE_NB to a_base. Once a_base ≥ s it saturates and a_o is all zeros.
  - a_o is valid on the start_o cycle.
- Collecting results:
  - In RUN, res_push_i writes res_i to res_mem[r_idx] and increments r_idx.
  - A push with r_idx = s is dropped and sets err_o.
- Completion:
  - done_i in RUN moves to DONE.
  - If r_idx ≠ s at that point, err_o is set.
  - If res_push_i and done_i arrive in the same cycle, the push is written first, then the count is checked.
- err_o clears only on reset or on go_i.
- Host read: rd_data_o = res_mem[rd_addr_i] on the next cycle, in any state.
- Simultaneous b_fetch_i, p_fetch_i and a_shift_i in one cycle are all honoured independently.

Optional Feature:
- Macro: FIOS_FEEDER_CHAIN_EN.
- Defined:
  - Adds input chain_i (1 bit).
  - The b memory and the result memory are two physical banks with a select bit, bsel (reset 0).
  - go_i with chain_i = 1 toggles bsel in the go edge, so the previous result becomes the b operand and the old b bank receives new results.
  - Host b loads always target the current b bank. rd_data_o always reads the current result bank.
- Undefined: the banks are fixed, and there is no chain_i port.

Test Plan:
- Basic run, s = 8, PE_NB = 8: load a = 1..8, b = 9..16, p = 17..24, then pulse go_i.
  - start_o pulses once and a_o holds words 1..8.
  - Eight b_fetch_i pulses give b_o = 9..16, then 9 again on wrap.
- Fold window, PE_NB = 3, s = 8: two a_shift_i pulses.
  - a_o words are {1,2,3}, then {4,5,6}, then {7,8,0}.
  - A third shift gives all zeros.
- Result path: eight res_push_i with res_i = 0x100+k, then done_i.
  - res_valid_o = 1 and err_o = 0.
  - rd_addr_i = 5 gives rd_data_o = 0x105 one cycle later.
- Protocol errors:
  - Nine pushes: the ninth is dropped and err_o = 1.
  - done_i after six pushes: err_o = 1.
  - A following go_i clears err_o.
- Reset mid-RUN: drive reset_i low after three b_fetch_i pulses.
  - Outputs go to 0 immediately, with no clock needed.
  - After release and go_i, b_o = b_mem[0] again.
- Chain (macro defined): complete a run with results R, then go_i with chain_i = 1.
  - b_o streams R[0..7].
  - A ld_en_i issued during RUN is ignored.
